// File: rtl/mpt_plb.sv
// mpt_plb: fully associative Protection Lookaside Buffer in front of the MPT walker.
// Caches per-page permissions tagged by {sdid, paddr[PLEN-1:12]}. A hit answers two cycles after
// accept. A miss walks, fills the result and then answers.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   mmpt_mode_i, mmpt_sdid_i current MPT mode (0 = BARE) and supervisor domain ID
//   flush_i                  invalidate all entries
//   req_*                    permission check request (valid/ready), one-cycle response pulse
//   ptw_req_*, ptw_resp_*    walker request (valid/ready) and one-cycle walker result
//   perf_hits_o/misses_o     saturating lookup counters
//
// Optional feature: define MPT_PLB_PERF_CNT_EN to build the perf counters. When it is
// undefined, both perf outputs are tied to 0.
module mpt_plb #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned PLEN        = 56,
  parameter int unsigned SDID_LEN    = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [3:0]          mmpt_mode_i,
  input  logic [SDID_LEN-1:0] mmpt_sdid_i,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [PLEN-1:0]     req_paddr_i,
  input  logic [1:0]          req_access_i,
  output logic                resp_valid_o,
  output logic                resp_allowed_o,
  output logic                resp_fault_o,
  output logic [2:0]          resp_fault_code_o,
  output logic                ptw_req_valid_o,
  input  logic                ptw_req_ready_i,
  output logic [PLEN-1:0]     ptw_req_paddr_o,
  input  logic                ptw_resp_valid_i,
  input  logic [1:0]          ptw_resp_perm_i,
  input  logic                ptw_resp_error_i,
  input  logic [2:0]          ptw_resp_code_i,
  output logic [31:0]         perf_hits_o,
  output logic [31:0]         perf_misses_o
);

  localparam int unsigned TagW = PLEN - 12;
  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);

  typedef enum logic [2:0] {StIdle, StLookup, StPtwReq, StPtwWait, StResp} state_e;

  state_e                state_q;
  logic                  ready_en_q;  // keeps req_ready_o low while reset is asserted
  logic [PLEN-1:0]       paddr_q;
  logic [1:0]            access_q;
  logic [SDID_LEN-1:0]   sdid_q;
  logic                  flush_seen_q;  // flush observed during the current walk
  logic                  allowed_q;
  logic                  fault_q;
  logic [2:0]            code_q;
  logic [IdxW-1:0]       rr_ptr_q;
  logic [NUM_ENTRIES-1:0] ent_valid_q;
  logic [TagW-1:0]       ent_tag_q  [NUM_ENTRIES];
  logic [SDID_LEN-1:0]   ent_sdid_q [NUM_ENTRIES];
  logic [1:0]            ent_perm_q [NUM_ENTRIES];

  logic                  hit;
  logic [1:0]            hit_perm;
  logic                  has_free;
  logic [IdxW-1:0]       free_idx;
  logic [IdxW-1:0]       fill_idx;
  logic                  bare;

  function automatic logic perm_ok(input logic [1:0] acc, input logic [1:0] perm);
    case (acc)
      2'd1:    return perm != 2'd0;  // READ: RX, RW, RWX
      2'd2:    return perm[1];       // WRITE: RW, RWX
      2'd3:    return perm[0];       // EXEC: RX, RWX
      default: return 1'b0;          // NONE
    endcase
  endfunction

  assign bare = (mmpt_mode_i == 4'd0);

  // Parallel tag match; fills only happen on misses, so at most one entry can match.
  always_comb begin
    hit      = 1'b0;
    hit_perm = 2'd0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ent_valid_q[i] && ent_sdid_q[i] == sdid_q && ent_tag_q[i] == paddr_q[PLEN-1:12]) begin
        hit      = 1'b1;
        hit_perm = hit_perm | ent_perm_q[i];
      end
    end
  end

  // Lowest-index invalid entry, otherwise the round-robin victim.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IdxW'(i);
      end
    end
    fill_idx = has_free ? free_idx : rr_ptr_q;
  end

  assign req_ready_o       = (state_q == StIdle) && ready_en_q && !flush_i;
  assign resp_valid_o      = (state_q == StResp);
  assign resp_allowed_o    = allowed_q;
  assign resp_fault_o      = fault_q;
  assign resp_fault_code_o = code_q;
  assign ptw_req_valid_o   = (state_q == StPtwReq);
  assign ptw_req_paddr_o   = paddr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      ready_en_q   <= 1'b0;
      paddr_q      <= '0;
      access_q     <= '0;
      sdid_q       <= '0;
      flush_seen_q <= 1'b0;
      allowed_q    <= 1'b0;
      fault_q      <= 1'b0;
      code_q       <= '0;
      rr_ptr_q     <= '0;
      ent_valid_q  <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_tag_q[i]  <= '0;
        ent_sdid_q[i] <= '0;
        ent_perm_q[i] <= '0;
      end
    end else begin
      ready_en_q <= 1'b1;
      if (flush_i) begin
        ent_valid_q <= '0;
        rr_ptr_q    <= '0;
      end
      case (state_q)
        StIdle: begin
          if (req_valid_i && req_ready_o) begin
            paddr_q  <= req_paddr_i;
            access_q <= req_access_i;
            sdid_q   <= mmpt_sdid_i;
            state_q  <= StLookup;
          end
        end
        StLookup: begin
          // A flush in this cycle does not affect the lookup result.
          if (bare || hit) begin
            allowed_q <= bare ? 1'b1 : perm_ok(access_q, hit_perm);
            fault_q   <= 1'b0;
            code_q    <= '0;
            state_q   <= StResp;
          end else begin
            flush_seen_q <= 1'b0;
            state_q      <= StPtwReq;
          end
        end
        StPtwReq: begin
          if (flush_i) flush_seen_q <= 1'b1;
          if (ptw_req_ready_i) state_q <= StPtwWait;
        end
        StPtwWait: begin
          if (ptw_resp_valid_i) begin
            if (ptw_resp_error_i) begin
              allowed_q <= 1'b0;
              fault_q   <= 1'b1;
              code_q    <= ptw_resp_code_i;
            end else begin
              allowed_q <= perm_ok(access_q, ptw_resp_perm_i);
              fault_q   <= 1'b0;
              code_q    <= '0;
              // A flush anywhere in the walk (including this cycle) drops the fill.
              if (!flush_seen_q && !flush_i) begin
                ent_valid_q[fill_idx] <= 1'b1;
                ent_tag_q[fill_idx]   <= paddr_q[PLEN-1:12];
                ent_sdid_q[fill_idx]  <= sdid_q;
                ent_perm_q[fill_idx]  <= ptw_resp_perm_i;
                if (!has_free) rr_ptr_q <= rr_ptr_q + IdxW'(1);
              end
            end
            state_q <= StResp;
          end else if (flush_i) begin
            flush_seen_q <= 1'b1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MPT_PLB_PERF_CNT_EN
  logic [31:0] hits_q;
  logic [31:0] misses_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (state_q == StLookup && !bare) begin
      if (hit) begin
        if (hits_q != '1) hits_q <= hits_q + 32'd1;
      end else begin
        if (misses_q != '1) misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign perf_hits_o   = hits_q;
  assign perf_misses_o = misses_q;
`else
  assign perf_hits_o   = '0;
  assign perf_misses_o = '0;
`endif

endmodule
